// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display controller.
// Holds the status codes, capture FSM states, segment constants and scan helpers.
// Pure declarations; no logic state.
package calc_pkg;

  // Calculator status bus encoding
  typedef enum logic [1:0] {
    ST_ERRO  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10,
    ST_PRINT = 2'b11
  } status_e;

  // Capture FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_ERR  = 2'b10
  } cap_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;

  localparam int NUM_DIGITS = 8;

  // Active-low one-hot digit enable for a scan index
  function automatic logic [7:0] an_onehot_n(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Seven-segment glyph decoder: 4-bit value to active-low {g,f,e,d,c,b,a}.
// Purely combinational, zero latency.
// Blank input forces all segments off; values 10-15 render as a dash.
module seg7_dec
  import calc_pkg::*;
(
  input  logic [3:0] i_val,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Glyph lookup with blanking override
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_val)
        4'd0:    o_seg = 7'h40;
        4'd1:    o_seg = 7'h79;
        4'd2:    o_seg = 7'h24;
        4'd3:    o_seg = 7'h30;
        4'd4:    o_seg = 7'h19;
        4'd5:    o_seg = 7'h12;
        4'd6:    o_seg = 7'h02;
        4'd7:    o_seg = 7'h78;
        4'd8:    o_seg = 7'h00;
        4'd9:    o_seg = 7'h10;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/calc_display_ctrl.sv
// Captures calculator digit frames and multiplexes them onto an 8-digit 7-seg display.
// an/seg registered, updated on the same edge as the scan index (1-edge digit-write to glyph).
// No backpressure: writes are accepted every cycle; scan runs freely from the prescaler.
module calc_display_ctrl
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000
)(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_status,
  input  logic [3:0] i_data,
  input  logic [3:0] i_pos,
  output logic [7:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic       o_frame_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRES_TC = PW'(SCAN_DIV - 1);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  cap_state_e       r_state;
  logic [7:0][3:0]  r_digit;
  logic [7:0]       r_valid;
  logic [PW-1:0]    r_pres;
  logic [2:0]       r_scan;
  logic             w_tc;
  logic [2:0]       w_scan_nxt;
  logic [7:0]       w_nz;
  logic [7:0]       w_above;
  logic [3:0]       w_cur_dig;
  logic             w_cur_vld;
  logic             w_lz_blank;
  logic             w_dec_blank;
  logic [6:0]       w_dec_seg;
  logic [6:0]       w_seg_nxt;

  // Reset asserts immediately, releases two edges later in step with the clock
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Capture FSM: error wins over everything, a new frame clears stale digits
  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_digit <= '0;
      r_valid <= '0;
    end else if (i_status == ST_ERRO) begin
      r_state <= S_ERR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_status == ST_PRINT) begin
            r_state <= S_LOAD;
            r_valid <= '0;
            if (!i_pos[3]) begin
              r_digit[i_pos[2:0]] <= i_data;
              r_valid[i_pos[2:0]] <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (!i_pos[3]) begin
            r_digit[i_pos[2:0]] <= i_data;
            r_valid[i_pos[2:0]] <= 1'b1;
          end
          if (i_pos == 4'd8 || i_status == ST_BUSY || i_status == ST_READY)
            r_state <= S_IDLE;
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign w_tc       = (r_pres == PRES_TC);
  assign w_scan_nxt = w_tc ? r_scan + 3'd1 : r_scan;

  // Nonzero valid digits, used for leading-zero suppression
  always_comb begin
    w_nz = '0;
    for (int j = 0; j < NUM_DIGITS; j++)
      w_nz[j] = r_valid[j] && (r_digit[j] != 4'd0);
  end

  assign w_above     = (w_nz >> w_scan_nxt) >> 1;
  assign w_cur_dig   = r_digit[w_scan_nxt];
  assign w_cur_vld   = r_valid[w_scan_nxt];
  assign w_lz_blank  = (w_scan_nxt != 3'd0) && (w_cur_dig == 4'd0) && !(|w_above);
  assign w_dec_blank = !w_cur_vld || w_lz_blank;

  seg7_dec u_dec (
    .i_val   (w_cur_dig),
    .i_blank (w_dec_blank),
    .o_seg   (w_dec_seg)
  );

  // Error screen overrides stored digits: "Erro" on digits 3..0, rest blank
  always_comb begin
    w_seg_nxt = w_dec_seg;
    if (r_state == S_ERR) begin
      case (w_scan_nxt)
        3'd3:    w_seg_nxt = SEG_E;
        3'd2:    w_seg_nxt = SEG_R;
        3'd1:    w_seg_nxt = SEG_R;
        3'd0:    w_seg_nxt = SEG_O;
        default: w_seg_nxt = SEG_BLANK;
      endcase
    end
  end

  // Prescaler, scan index and registered display outputs
  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pres       <= '0;
      r_scan       <= 3'd0;
      o_an         <= 8'hFF;
      o_seg        <= SEG_BLANK;
      o_frame_done <= 1'b0;
    end else begin
      r_pres       <= w_tc ? '0 : r_pres + 1'b1;
      r_scan       <= w_scan_nxt;
      o_an         <= an_onehot_n(w_scan_nxt);
      o_seg        <= w_seg_nxt;
      o_frame_done <= w_tc && (r_scan == 3'd7);
    end
  end

  assign o_dp = 1'b1;

endmodule
